// File: rtl/rename_recovery_ctrl.sv
// Rename-state recovery sequencer: drain commits, copy R-RAT into F-RAT, rebuild the free vector.
// Optional RECOVERY_PERF_EN adds recovery and stall-cycle performance counters.
module rename_recovery_ctrl #(
  parameter int SUPER   = 2,
  parameter int PHYS_SZ = 64,
  parameter int NLREG   = 32,
  parameter int LANES   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                annul_req,
  input  logic                                commit_busy,
  output logic [LANES*$clog2(NLREG)-1:0]      rrat_rd_idx,
  input  logic [LANES*$clog2(PHYS_SZ)-1:0]    rrat_rd_data,
  output logic [LANES-1:0]                    frat_wr_en,
  output logic [LANES*$clog2(NLREG)-1:0]      frat_wr_idx,
  output logic [LANES*$clog2(PHYS_SZ)-1:0]    frat_wr_data,
  output logic                                free_load,
  output logic [PHYS_SZ-1:0]                  free_load_vec,
  output logic                                rename_stall,
  output logic                                recover_done,
  output logic                                recover_err
`ifdef RECOVERY_PERF_EN
  ,
  output logic [31:0]                         perf_recov_cnt,
  output logic [31:0]                         perf_stall_cyc
`endif
);

  localparam int PW    = $clog2(PHYS_SZ);
  localparam int LW    = $clog2(NLREG);
  localparam int NCOPY = NLREG / LANES;
  localparam int CW    = (NCOPY > 1) ? $clog2(NCOPY) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_COPY  = 3'd2;
  localparam logic [2:0] S_FREE  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(NCOPY - 1);

  if (SUPER < 1 || LANES < 1 || (NLREG % LANES) != 0) begin : g_bad_cfg
    $error("rename_recovery_ctrl: invalid SUPER/LANES/NLREG configuration");
  end

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      copy_cnt_q, copy_cnt_d;
  logic [PHYS_SZ-1:0] in_use_q, in_use_d;
  logic               err_q, err_d;

  logic [PW-1:0]      lane_preg [LANES];
  logic [PHYS_SZ-1:0] copy_hits;
  logic               copy_dup;

  function automatic logic [PHYS_SZ-1:0] preg_onehot(input logic [PW-1:0] p);
    logic [PHYS_SZ-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_preg[l] = rrat_rd_data[l*PW +: PW];
    end
  end

  // A lane duplicates if its preg was seen in an earlier cycle or by a lower lane this cycle.
  always_comb begin
    copy_hits = '0;
    copy_dup  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (|((in_use_q | copy_hits) & preg_onehot(lane_preg[l]))) begin
        copy_dup = 1'b1;
      end
      copy_hits = copy_hits | preg_onehot(lane_preg[l]);
    end
  end

  always_comb begin
    state_d    = state_q;
    copy_cnt_d = copy_cnt_q;
    in_use_d   = in_use_q;
    err_d      = err_q;
    if (annul_req) begin
      state_d    = S_DRAIN;
      copy_cnt_d = '0;
      in_use_d   = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        S_DRAIN: begin
          if (!commit_busy) state_d = S_COPY;
        end
        S_COPY: begin
          in_use_d = in_use_q | copy_hits;
          err_d    = err_q | copy_dup;
          if (copy_cnt_q == CNT_LAST) begin
            state_d = S_FREE;
          end else begin
            copy_cnt_d = copy_cnt_q + 1'b1;
          end
        end
        S_FREE:  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      copy_cnt_q <= '0;
      in_use_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      copy_cnt_q <= copy_cnt_d;
      in_use_q   <= in_use_d;
      err_q      <= err_d;
    end
  end

  // COPY streams LANES consecutive logical registers per cycle straight from R-RAT to F-RAT.
  always_comb begin
    rrat_rd_idx  = '0;
    frat_wr_en   = '0;
    frat_wr_idx  = '0;
    frat_wr_data = '0;
    if (state_q == S_COPY) begin
      for (int l = 0; l < LANES; l++) begin
        rrat_rd_idx[l*LW +: LW] = LW'(int'(copy_cnt_q) * LANES + l);
        frat_wr_idx[l*LW +: LW] = LW'(int'(copy_cnt_q) * LANES + l);
      end
      frat_wr_en   = '1;
      frat_wr_data = rrat_rd_data;
    end
  end

  // A same-cycle annul aborts the pass, so its completion pulses are withheld.
  assign free_load     = (state_q == S_FREE) && !annul_req;
  assign free_load_vec = free_load ? ~in_use_q : '0;
  assign recover_done  = (state_q == S_DONE) && !annul_req;
  assign rename_stall  = (state_q != S_IDLE) || annul_req;
  assign recover_err   = err_q;

`ifdef RECOVERY_PERF_EN
  logic [31:0] perf_recov_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_recov_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (recover_done) perf_recov_q <= perf_recov_q + 32'd1;
      if (rename_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_recov_cnt = perf_recov_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Directed bench for rename_recovery_ctrl with R-RAT/F-RAT models and a free-vector scoreboard.
module tb_rename_recovery_ctrl;

  localparam int PHYS_SZ = 64;
  localparam int NLREG   = 32;
  localparam int LANES   = 4;
  localparam int PW      = 6;
  localparam int LW      = 5;
  localparam int NCOPY   = NLREG / LANES;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  annul_req;
  logic                  commit_busy;
  logic [LANES*LW-1:0]   rrat_rd_idx;
  logic [LANES*PW-1:0]   rrat_rd_data;
  logic [LANES-1:0]      frat_wr_en;
  logic [LANES*LW-1:0]   frat_wr_idx;
  logic [LANES*PW-1:0]   frat_wr_data;
  logic                  free_load;
  logic [PHYS_SZ-1:0]    free_load_vec;
  logic                  rename_stall;
  logic                  recover_done;
  logic                  recover_err;
`ifdef RECOVERY_PERF_EN
  logic [31:0]           perf_recov_cnt;
  logic [31:0]           perf_stall_cyc;
`endif

  rename_recovery_ctrl #(
    .SUPER(2), .PHYS_SZ(PHYS_SZ), .NLREG(NLREG), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .annul_req(annul_req), .commit_busy(commit_busy),
    .rrat_rd_idx(rrat_rd_idx), .rrat_rd_data(rrat_rd_data),
    .frat_wr_en(frat_wr_en), .frat_wr_idx(frat_wr_idx), .frat_wr_data(frat_wr_data),
    .free_load(free_load), .free_load_vec(free_load_vec),
    .rename_stall(rename_stall), .recover_done(recover_done), .recover_err(recover_err)
`ifdef RECOVERY_PERF_EN
    , .perf_recov_cnt(perf_recov_cnt), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] rrat [NLREG];
  logic [PW-1:0] frat [NLREG];

  always_comb begin
    rrat_rd_data = '0;
    for (int l = 0; l < LANES; l++) begin
      rrat_rd_data[l*PW +: PW] = rrat[rrat_rd_idx[l*LW +: LW]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLREG; i++) frat[i] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (frat_wr_en[l]) frat[frat_wr_idx[l*LW +: LW]] <= frat_wr_data[l*PW +: PW];
      end
    end
  end

  typedef struct {
    logic [PHYS_SZ-1:0] vec;
    int                 free_at;
  } exp_t;

  exp_t               sb[$];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 c0;
  logic [PHYS_SZ-1:0] last_vec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PHYS_SZ-1:0] exp_free_vec();
    logic [PHYS_SZ-1:0] used;
    used = '0;
    for (int i = 0; i < NLREG; i++) used[rrat[i]] = 1'b1;
    return ~used;
  endfunction

  // Called just after a rising edge; leaves the bench just after the next rising edge (c1).
  task automatic annul_now(input int busy_cyc);
    exp_t e;
    annul_req   = 1'b1;
    commit_busy = (busy_cyc > 0);
    c0          = cyc;
    sb.delete();
    e.vec     = exp_free_vec();
    e.free_at = 2 + NCOPY + busy_cyc;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_c0", rename_stall, 1);
    @(posedge clk); #1;
    annul_req = 1'b0;
  endtask

  task automatic finish(input int busy_cyc);
    int   k;
    bit   got;
    exp_t e;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      k = cyc - c0;
      if (k == 1 + busy_cyc) commit_busy = 1'b0;
      @(negedge clk);
      chk("wr_en", frat_wr_en,
          (k >= 2 + busy_cyc && k < 2 + busy_cyc + NCOPY) ? 64'hF : 64'h0);
      if (k == 2 + busy_cyc) chk("rd_idx_first", rrat_rd_idx, {5'd3, 5'd2, 5'd1, 5'd0});
      if (free_load) begin
        got = 1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("free_at", k, e.free_at);
          chk("free_vec", free_load_vec, e.vec);
        end
        last_vec = free_load_vec;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("free_seen", 0, 1);
    @(negedge clk);
    chk("done_pulse", recover_done, 1);
    chk("stall_done", rename_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_after", rename_stall, 0);
    chk("done_after", recover_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit spurious;
    rst         = 1'b1;
    annul_req   = 1'b0;
    commit_busy = 1'b0;
    for (int i = 0; i < NLREG; i++) rrat[i] = PW'(32 + i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", rename_stall, 0);
    chk("rst_free", free_load, 0);
    chk("rst_vec", free_load_vec, 0);
    chk("rst_done", recover_done, 0);
    chk("rst_err", recover_err, 0);
    chk("rst_wr_en", frat_wr_en, 0);

    // Baseline recovery plus copied contents and free vector
    @(posedge clk); #1;
    annul_now(0);
    finish(0);
    for (int i = 0; i < NLREG; i++) chk($sformatf("frat_%0d", i), frat[i], 32 + i);
    chk("free_vec_const", last_vec, 64'h0000_0000_FFFF_FFFF);
    chk("err_clean", recover_err, 0);

    // Back-to-back second recovery
    @(posedge clk); #1;
    annul_now(0);
    finish(0);
`ifdef RECOVERY_PERF_EN
    chk("perf_recov", perf_recov_cnt, 2);
    chk("perf_stall", perf_stall_cyc, 24);
`endif

    // Commit path busy for 5 cycles after annul
    @(posedge clk); #1;
    annul_now(5);
    finish(5);

    // Re-annul during the third COPY cycle
    @(posedge clk); #1;
    annul_now(0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_free", free_load, 0);
      @(posedge clk); #1;
    end
    annul_now(0);
    finish(0);
    chk("sb_drained", sb.size(), 0);

    // Duplicate physical register in R-RAT
    rrat[3]  = 6'd40;
    rrat[17] = 6'd40;
    @(posedge clk); #1;
    annul_now(0);
    finish(0);
    chk("err_set", recover_err, 1);
    repeat (3) @(posedge clk);
    #1 chk("err_held", recover_err, 1);
    rrat[3]  = 6'd35;
    rrat[17] = 6'd49;
    annul_now(0);
    chk("err_cleared", recover_err, 0);
    finish(0);
    chk("err_stays_clear", recover_err, 0);

    // Reset in the middle of COPY
    @(posedge clk); #1;
    annul_now(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_stall", rename_stall, 0);
    chk("rst_mid_wr_en", frat_wr_en, 0);
    spurious = 0;
    repeat (14) begin
      @(negedge clk);
      if (free_load || recover_done || rename_stall) spurious = 1;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_pulse", spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
